// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line in, byte/valid/ready handshake and error pulses out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err
    );

    modport slave (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1) with a held valid/ready output and one-cycle error pulses.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits (8E1).
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [3:0]       tick_cnt, tick_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             ferr_q, ferr_n;
    logic             ovr_q, ovr_n;
    logic             tick_c, mid_c, done_c;
`ifdef UART_RX_PARITY_EN
    logic             pbad_q, pbad_n;
    logic             perr_q, perr_n;
`endif

    // Two-flop synchronizer; resets to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q   <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            ferr_q   <= ferr_n;
            ovr_q    <= ovr_n;
`ifdef UART_RX_PARITY_EN
            pbad_q   <= pbad_n;
            perr_q   <= perr_n;
`endif
        end
    end

    assign tick_c = (div_cnt == DIV_LAST);
    // Bit-centre event: 16 ticks after the previous sample point
    assign mid_c  = tick_c && (tick_cnt == 4'd15);

    always_comb begin
        state_n = state;
        div_n   = '0;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = data_q;
        valid_n = valid_q;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        done_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_n  = pbad_q;
        perr_n  = 1'b0;
`endif

        if (state != IDLE && state != BREAK) begin
            div_n = tick_c ? '0 : DIV_W'(div_cnt + DIV_W'(1));
            if (tick_c) tick_n = 4'(tick_cnt + 4'd1);
        end

        case (state)
            IDLE: begin
                tick_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (tick_c && tick_cnt == 4'd7) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_c) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    bit_n   = 3'(bit_cnt + 3'd1);
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'd7) state_n = PARITY;
`else
                    if (bit_cnt == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_c) begin
                    pbad_n  = rx_s ^ (^shreg);
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (mid_c) begin
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (pbad_q) perr_n = 1'b1;
                        else        done_c = 1'b1;
`else
                        done_c = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
`ifdef UART_RX_PARITY_EN
                        perr_n  = pbad_q;
`endif
                    end
                end
            end
            BREAK: begin
                tick_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Output buffer: handshake drains it; a completion refills it or is dropped as overrun
        if (valid_q && bus.rx_ready) valid_n = 1'b0;
        if (done_c) begin
            if (valid_q && !bus.rx_ready) begin
                ovr_n = 1'b1;
            end else begin
                valid_n = 1'b1;
                data_n  = shreg;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (864 clocks per bit).
module tb_uart_rx;
    localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Start-bit drive to rx_valid seen: 3 sync/detect clocks + 8 ticks + 9 bit periods (+ parity)
    localparam int EXP_LAT = 3 + 8 * 54 + (9 + PBITS) * BIT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if bus ();
    uart_rx dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid, n_ferr, n_ovr, n_perr, n_unstable, first_valid, start_cyc;
    logic [7:0] last_data, p_data;
    logic p_valid = 1'b0, p_hs = 1'b0;

    // Output monitor on the falling edge
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid++;
            last_data = bus.rx_data;
            if (first_valid < 0) first_valid = cyc;
        end
        if (bus.frame_err)  n_ferr++;
        if (bus.overrun)    n_ovr++;
        if (bus.parity_err) n_perr++;
        if (p_valid && !p_hs && bus.rx_valid && bus.rx_data != p_data) n_unstable++;
        p_valid = bus.rx_valid;
        p_hs    = bus.rx_valid && bus.rx_ready;
        p_data  = bus.rx_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        n_valid = 0; n_ferr = 0; n_ovr = 0; n_perr = 0; n_unstable = 0;
        first_valid = -1; last_data = 8'h00;
    endtask

    // One frame; a zero stop bit is followed by low_hold extra low clocks before idling high
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok, input int low_hold);
        start_cyc = cyc;
        bus.rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            step(BIT);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = par_ok ? ^d : ~^d;
        step(BIT);
`endif
        bus.rx = stop;
        step(BIT);
        if (!stop) step(low_hold);
        bus.rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_ok;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0};
        vt[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0};
        vt[2] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0};
        vt[3] = '{8'h3C, 1'b0, 1'b1, 0, 8'h00, 1};
        vt[4] = '{8'h81, 1'b1, 1'b1, 1, 8'h81, 0};
        vt[5] = '{8'h55, 1'b1, 1'b1, 1, 8'h55, 0};

        rst = 1'b1;
        bus.rx = 1'b1;
        bus.rx_ready = 1'b1;
        clear_mon();
        step(3);
        chk("reset rx_valid",   int'(bus.rx_valid),   0);
        chk("reset rx_data",    int'(bus.rx_data),    0);
        chk("reset frame_err",  int'(bus.frame_err),  0);
        chk("reset overrun",    int'(bus.overrun),    0);
        chk("reset parity_err", int'(bus.parity_err), 0);
        rst = 1'b0;
        step(20);

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_frame(vt[i].d, vt[i].stop, vt[i].par_ok, 2000);
            step(1000);
            chk($sformatf("vec%0d valid cycles", i), n_valid, vt[i].exp_valid);
            chk($sformatf("vec%0d frame_err", i), n_ferr, vt[i].exp_ferr);
            chk($sformatf("vec%0d overrun", i), n_ovr, 0);
            chk($sformatf("vec%0d parity_err", i), n_perr, 0);
            if (vt[i].exp_valid != 0) begin
                chk($sformatf("vec%0d rx_data", i), int'(last_data), int'(vt[i].exp_data));
                chk($sformatf("vec%0d latency", i), first_valid - start_cyc, EXP_LAT);
            end
        end

        // Short low glitch is a false start; the next frame must still be received
        clear_mon();
        bus.rx = 1'b0;
        step(200);
        bus.rx = 1'b1;
        step(1500);
        chk("glitch valid", n_valid, 0);
        chk("glitch frame_err", n_ferr, 0);
        send_frame(8'h96, 1'b1, 1'b1, 0);
        step(1000);
        chk("after glitch valid", n_valid, 1);
        chk("after glitch data", int'(last_data), 'h96);

        // Overrun: second byte dropped while the first is unconsumed
        clear_mon();
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 0);
        step(1000);
        send_frame(8'h22, 1'b1, 1'b1, 0);
        step(1000);
        chk("overrun pulses", n_ovr, 1);
        chk("overrun held valid", int'(bus.rx_valid), 1);
        chk("overrun held data", int'(bus.rx_data), 'h11);
        chk("overrun data stable", n_unstable, 0);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        chk("handshake valid falls", int'(bus.rx_valid), 0);
        step(5);
        chk("no revalidation", int'(bus.rx_valid), 0);
        bus.rx_ready = 1'b1;
        step(100);

        // Reset during bit 3 of 0xFF aborts the frame silently
        clear_mon();
        fork
            send_frame(8'hFF, 1'b1, 1'b1, 0);
            begin
                step(BIT * 4 + 400);
                rst = 1'b1;
                step(5);
                chk("midreset valid", int'(bus.rx_valid), 0);
                rst = 1'b0;
            end
        join
        step(1000);
        chk("aborted frame valid", n_valid, 0);
        chk("aborted frame ferr", n_ferr, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        step(1000);
        chk("post-reset valid", n_valid, 1);
        chk("post-reset data", int'(last_data), 'h5A);

`ifdef UART_RX_PARITY_EN
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0, 0);
        step(1000);
        chk("bad parity perr", n_perr, 1);
        chk("bad parity valid", n_valid, 0);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, 0);
        step(1000);
        chk("good parity valid", n_valid, 1);
        chk("good parity data", int'(last_data), 'h07);
        chk("good parity perr", n_perr, 0);
        clear_mon();
        send_frame(8'h07, 1'b0, 1'b0, 2000);
        step(1000);
        chk("both errors perr", n_perr, 1);
        chk("both errors ferr", n_ferr, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
